// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// scoreboard set request and the write-conflict pulse.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     wr_conflict;

  // Pipeline side: issues reads, writes and scoreboard sets.
  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_pend, wr_conflict
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data, sb_set_en, sb_set_addr,
    output rd_data, rd_pend, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports,
// optional write-to-read bypass and a per-entry pending (scoreboard) bit.
// All state changes on the rising edge; reset is synchronous, active low.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_r;
  logic              conflict_r;
  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic              set_ok_s;

  // True when the address targets the hardwired zero entry.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Qualify write and scoreboard requests; anything aimed at the zero entry is dropped.
  always_comb begin
    wr0_ok_s = 1'b0;
    wr1_ok_s = 1'b0;
    set_ok_s = 1'b0;
    if (is_zero_addr(bus.wr0_addr)) wr0_ok_s = 1'b0;
    else                            wr0_ok_s = bus.wr0_en;
    if (is_zero_addr(bus.wr1_addr)) wr1_ok_s = 1'b0;
    else                            wr1_ok_s = bus.wr1_en;
    if (is_zero_addr(bus.sb_set_addr)) set_ok_s = 1'b0;
    else                               set_ok_s = bus.sb_set_en;
  end

  // Storage update: port 1 overrides port 0 when both hit the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_ok_s && (bus.wr1_addr == ADDR_W'(i)))      mem_r[i] <= bus.wr1_data;
        else if (wr0_ok_s && (bus.wr0_addr == ADDR_W'(i))) mem_r[i] <= bus.wr0_data;
      end
    end
  end

  // Scoreboard: a new producer (set) beats a completing write to the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_ok_s && (bus.sb_set_addr == ADDR_W'(i))) begin
          pend_r[i] <= 1'b1;
        end else if ((wr1_ok_s && (bus.wr1_addr == ADDR_W'(i))) ||
                     (wr0_ok_s && (bus.wr0_addr == ADDR_W'(i)))) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

  // One-cycle pulse flagging that both write ports hit the same live entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= wr0_ok_s && wr1_ok_s && (bus.wr0_addr == bus.wr1_addr);
    end
  end

  assign bus.wr_conflict = conflict_r;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              pend_s;
    logic              set_hit_s;

    assign addr_s    = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign set_hit_s = set_ok_s && (bus.sb_set_addr == addr_s);

    // Read mux: zero entry, then bypass from port 1, then port 0, then storage.
    always_comb begin
      data_s = mem_r[addr_s];
      pend_s = pend_r[addr_s];
      if (is_zero_addr(addr_s)) begin
        data_s = {DATA_W{1'b0}};
        pend_s = 1'b0;
      end else if ((BYPASS != 0) && wr1_ok_s && (bus.wr1_addr == addr_s)) begin
        data_s = bus.wr1_data;
        pend_s = set_hit_s ? pend_r[addr_s] : 1'b0;
      end else if ((BYPASS != 0) && wr0_ok_s && (bus.wr0_addr == addr_s)) begin
        data_s = bus.wr0_data;
        pend_s = set_hit_s ? pend_r[addr_s] : 1'b0;
      end else begin
        data_s = mem_r[addr_s];
        pend_s = pend_r[addr_s];
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = data_s;
    assign bus.rd_pend[k]                  = pend_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg + bypass with 4 read ports,
// and plain storage without bypass with 2 read ports) driven by the same
// write/scoreboard stimulus and checked every cycle against an array model.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) ifa ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Shared stimulus
  logic        w0e, w1e, se;
  logic [4:0]  w0a, w1a, sa;
  logic [31:0] w0d, w1d;
  logic [4:0]  ra_a [4];
  logic [4:0]  ra_b [2];

  // Model: index 0 = dut_a (zero reg, bypass), index 1 = dut_b
  logic [31:0] mem_m  [2][32];
  logic        pend_m [2][32];
  logic        conf_m [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic apply();
    ifa.wr0_en = w0e; ifa.wr0_addr = w0a; ifa.wr0_data = w0d;
    ifa.wr1_en = w1e; ifa.wr1_addr = w1a; ifa.wr1_data = w1d;
    ifa.sb_set_en = se; ifa.sb_set_addr = sa;
    ifa.rd_addr = {ra_a[3], ra_a[2], ra_a[1], ra_a[0]};
    ifb.wr0_en = w0e; ifb.wr0_addr = w0a; ifb.wr0_data = w0d;
    ifb.wr1_en = w1e; ifb.wr1_addr = w1a; ifb.wr1_data = w1d;
    ifb.sb_set_en = se; ifb.sb_set_addr = sa;
    ifb.rd_addr = {ra_b[1], ra_b[0]};
  endtask

  task automatic idle();
    w0e = 1'b0; w1e = 1'b0; se = 1'b0;
  endtask

  function automatic bit ign(input int c, input logic [4:0] a);
    return (c == 0) && (a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
    if (ign(c, a)) return 32'h0;
    if (c == 0) begin
      if (w1e && w1a == a) return w1d;
      if (w0e && w0a == a) return w0d;
    end
    return mem_m[c][a];
  endfunction

  function automatic logic exp_pend(input int c, input logic [4:0] a);
    if (ign(c, a)) return 1'b0;
    if (c == 0 && ((w1e && w1a == a) || (w0e && w0a == a)) && !(se && sa == a))
      return 1'b0;
    return pend_m[c][a];
  endfunction

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic check_now();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("a_rd_data%0d", k), ifa.rd_data[k*32 +: 32], exp_data(0, ra_a[k]));
      cmp($sformatf("a_rd_pend%0d", k), ifa.rd_pend[k], exp_pend(0, ra_a[k]));
    end
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("b_rd_data%0d", k), ifb.rd_data[k*32 +: 32], exp_data(1, ra_b[k]));
      cmp($sformatf("b_rd_pend%0d", k), ifb.rd_pend[k], exp_pend(1, ra_b[k]));
    end
    cmp("a_wr_conflict", ifa.wr_conflict, conf_m[0]);
    cmp("b_wr_conflict", ifb.wr_conflict, conf_m[1]);
  endtask

  // Advance one rising edge and apply the architectural rules to the model.
  task automatic step();
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (!rst) begin
        for (int i = 0; i < 32; i++) begin
          mem_m[c][i] = 32'h0;
          pend_m[c][i] = 1'b0;
        end
        conf_m[c] = 1'b0;
      end else begin
        conf_m[c] = w0e && w1e && (w0a == w1a) && !ign(c, w0a);
        if (w0e && !ign(c, w0a)) begin mem_m[c][w0a] = w0d; pend_m[c][w0a] = 1'b0; end
        if (w1e && !ign(c, w1a)) begin mem_m[c][w1a] = w1d; pend_m[c][w1a] = 1'b0; end
        if (se && !ign(c, sa)) pend_m[c][sa] = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] raddr(input bit narrow);
    return narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) begin mem_m[c][i] = 32'h0; pend_m[c][i] = 1'b0; end
      conf_m[c] = 1'b0;
    end
    idle();
    w0a = 5'd0; w1a = 5'd0; sa = 5'd0; w0d = 32'h0; w1d = 32'h0;
    for (int k = 0; k < 4; k++) ra_a[k] = 5'd5;
    for (int k = 0; k < 2; k++) ra_b[k] = 5'd5;

    // 1. Reset discards a concurrent write
    rst = 1'b0; w0e = 1'b1; w0a = 5'd5; w0d = 32'hDEADBEEF;
    apply(); step(); step();
    rst = 1'b1; idle(); apply(); check_now();
    cmp("rst_a_data", ifa.rd_data[31:0], 32'h0);
    cmp("rst_a_pend", ifa.rd_pend[0], 1'b0);
    cmp("rst_a_conf", ifa.wr_conflict, 1'b0);
    cmp("rst_b_data", ifb.rd_data[31:0], 32'h0);
    step();

    // 2. Write/read with and without bypass
    w0e = 1'b1; w0a = 5'd3; w0d = 32'h12345678; ra_a[0] = 5'd3; ra_b[0] = 5'd3;
    apply(); check_now();
    cmp("byp_a_same", ifa.rd_data[31:0], 32'h12345678);
    cmp("nobyp_b_same", ifb.rd_data[31:0], 32'h0);
    step();
    idle(); apply(); check_now();
    cmp("byp_a_next", ifa.rd_data[31:0], 32'h12345678);
    cmp("nobyp_b_next", ifb.rd_data[31:0], 32'h12345678);
    step();

    // 3. Write priority and conflict pulse
    w0e = 1'b1; w0a = 5'd7; w0d = 32'hAAAA0000;
    w1e = 1'b1; w1a = 5'd7; w1d = 32'h0000BBBB;
    apply(); check_now(); step();
    idle(); ra_a[0] = 5'd7; ra_b[0] = 5'd7; apply(); check_now();
    cmp("prio_a", ifa.rd_data[31:0], 32'h0000BBBB);
    cmp("prio_b", ifb.rd_data[31:0], 32'h0000BBBB);
    cmp("conf_a_pulse", ifa.wr_conflict, 1'b1);
    step();
    apply(); check_now();
    cmp("conf_a_drop", ifa.wr_conflict, 1'b0);
    step();
    w0e = 1'b1; w0a = 5'd0; w0d = 32'h1; w1e = 1'b1; w1a = 5'd0; w1d = 32'h2;
    apply(); check_now(); step();
    idle(); apply(); check_now();
    cmp("conf_a_zero", ifa.wr_conflict, 1'b0);
    cmp("conf_b_zero", ifb.wr_conflict, 1'b1);
    step();

    // 4. Zero register
    w1e = 1'b1; w1a = 5'd0; w1d = 32'hFFFFFFFF; se = 1'b1; sa = 5'd0;
    ra_a[0] = 5'd0; ra_b[0] = 5'd0;
    apply(); check_now();
    cmp("zero_a_data", ifa.rd_data[31:0], 32'h0);
    cmp("zero_a_pend", ifa.rd_pend[0], 1'b0);
    step();
    idle(); apply(); check_now();
    cmp("zero_a_after", ifa.rd_data[31:0], 32'h0);
    cmp("zero_b_after", ifb.rd_data[31:0], 32'hFFFFFFFF);
    cmp("zero_b_pend", ifb.rd_pend[0], 1'b1);
    step();

    // 5. Scoreboard
    se = 1'b1; sa = 5'd9; ra_a[0] = 5'd9; ra_b[0] = 5'd9;
    apply(); check_now(); step();
    idle(); apply(); check_now();
    cmp("sb_set", ifa.rd_pend[0], 1'b1);
    step();
    w1e = 1'b1; w1a = 5'd9; w1d = 32'h5;
    apply(); check_now();
    cmp("sb_clr_byp", ifa.rd_pend[0], 1'b0);
    step();
    idle(); apply(); check_now();
    cmp("sb_clr_after", ifa.rd_pend[0], 1'b0);
    step();
    se = 1'b1; sa = 5'd9; w0e = 1'b1; w0a = 5'd9; w0d = 32'h6;
    apply(); check_now(); step();
    idle(); apply(); check_now();
    cmp("sb_set_wins", ifa.rd_pend[0], 1'b1);
    step();

    // 6. Four read ports
    w0e = 1'b1; w0a = 5'd1; w0d = 32'h11; w1e = 1'b1; w1a = 5'd2; w1d = 32'h22;
    apply(); check_now(); step();
    w1e = 1'b0; w0a = 5'd31; w0d = 32'h1F;
    apply(); check_now(); step();
    idle(); ra_a[0] = 5'd1; ra_a[1] = 5'd2; ra_a[2] = 5'd1; ra_a[3] = 5'd31;
    apply(); check_now();
    cmp("multiport", ifa.rd_data, {32'h1F, 32'h11, 32'h22, 32'h11});
    step();

    // Randomised traffic, biased toward address collisions
    for (int n = 0; n < 3000; n++) begin
      bit nar;
      nar = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 63) != 0);
      w0e = $urandom_range(0, 1) == 1; w0a = raddr(nar); w0d = $urandom;
      w1e = $urandom_range(0, 1) == 1; w1a = raddr(nar); w1d = $urandom;
      se  = $urandom_range(0, 2) == 0; sa  = raddr(nar);
      for (int k = 0; k < 4; k++) ra_a[k] = raddr(nar);
      for (int k = 0; k < 2; k++) ra_b[k] = raddr(nar);
      apply(); check_now(); step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
